// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock SRAM FIFO pointer/flag blocks.
// Holds the default address width, the derived depth and the Gray encoder.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 8;
  localparam int DEPTH         = 2 ** FIFO_ADDRSIZE;

  // Widest pointer any FIFO instance may use (ADDRSIZE up to 16, plus wrap bit).
  localparam int GRAY_MAX_W    = 17;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above it. Shared by the write- and read-side pointer blocks.
module gray2bin #(
  parameter int W = 9
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wptr_full_level.sv
// Write-domain pointer and flag generator: binary/Gray write pointers, SRAM
// write address, full, fill level, almost-full and sticky overflow flags.
module wptr_full_level
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = FIFO_ADDRSIZE,
  parameter int AFULL_EN = 1
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wptr_q,   wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q,        wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          woverflow_q,    woverflow_d;

  logic          wwrite;
  logic [PW-1:0] wq2_rbin;
  logic [PW-1:0] full_cmp;

  gray2bin #(.W(PW)) u_rptr_dec (
    .gray (wq2_rptr),
    .bin  (wq2_rbin)
  );

  // Full when the next write pointer sits exactly one lap ahead of the read
  // pointer: in Gray form that is the read pointer with its top two bits flipped.
  assign full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  always_comb begin
    wwrite         = winc & ~wfull_q;
    wbin_d         = wbin_q + PW'(wwrite);
    wptr_d         = PW'(bin2gray(GRAY_MAX_W'(wbin_d)));
    wfull_d        = (wptr_d == full_cmp);
    wlevel_d       = wbin_d - wq2_rbin;
    walmost_full_d = (AFULL_EN != 0) && (afull_thresh != '0) && (wlevel_d >= afull_thresh);
    woverflow_d    = (winc & wfull_q) | (woverflow_q & ~wovf_clr);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Bench for wptr_full_level (ADDRSIZE=4): directed scenarios plus random traffic,
// checked against an occupancy model built on unbounded write/read word counts.
module tb_wptr_full_level;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          winc;
  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] afull_thresh;
  logic          wovf_clr;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr;
  logic          wfull;
  logic          walmost_full;
  logic [PW-1:0] wlevel;
  logic          woverflow;

  wptr_full_level #(.ADDRSIZE(AW), .AFULL_EN(1)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .afull_thresh (afull_thresh),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: total words written / read since reset, plus flags.
  int w_tot, r_tot, m_level;
  bit m_full, m_afull, m_ovf;
  logic [PW-1:0] prev_wptr;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic step(input bit rst, input bit wr, input bit adv, input bit clr,
                      input logic [PW-1:0] thr);
    bit acc;
    acc = 1'b0;
    if (rst) r_tot = 0;
    else if (adv && r_tot < w_tot) r_tot++;
    wrst = rst; winc = wr; wovf_clr = clr; afull_thresh = thr;
    wq2_rptr = gray_of(r_tot);
    prev_wptr = wptr;
    @(posedge wclk);
    if (rst) begin
      w_tot = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      acc     = wr && !m_full;
      m_ovf   = (wr && m_full) || (m_ovf && !clr);
      w_tot  += int'(acc);
      m_level = w_tot - r_tot;
      m_full  = (m_level == DEPTH);
      m_afull = (thr != 0) && (m_level >= int'(thr));
    end
    @(negedge wclk);
    check_eq("waddr",     int'(waddr),        w_tot % DEPTH);
    check_eq("wptr",      int'(wptr),         int'(gray_of(w_tot)));
    check_eq("wfull",     int'(wfull),        int'(m_full));
    check_eq("wlevel",    int'(wlevel),       m_level);
    check_eq("walmost",   int'(walmost_full), int'(m_afull));
    check_eq("woverflow", int'(woverflow),    int'(m_ovf));
    if (!rst) check_eq("gray_1bit", $countones(wptr ^ prev_wptr), int'(acc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_tot = 0; r_tot = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; afull_thresh = '0; wq2_rptr = '0;
    @(negedge wclk);

    // Reset for two cycles, with a write request asserted to show reset priority.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check_eq("rst_wptr", int'(wptr), 0);

    // Fill 16 words with the read pointer parked at 0.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 0);
    check_eq("fill_wptr", int'(wptr), 5'b11000);
    check_eq("fill_full", int'(wfull), 1);

    // Writes while full are rejected and set the sticky overflow.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    check_eq("ovf_set", int'(woverflow), 1);
    check_eq("ovf_level", int'(wlevel), DEPTH);
    step(0, 1, 0, 1, 0);
    check_eq("ovf_set_wins", int'(woverflow), 1);
    step(0, 0, 0, 1, 0);
    check_eq("ovf_clr", int'(woverflow), 0);

    // Almost-full threshold at 12, then disabled.
    step(1, 0, 0, 0, 12);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 12);
    check_eq("afull_at11", int'(walmost_full), 0);
    step(0, 1, 0, 0, 12);
    check_eq("afull_at12", int'(walmost_full), 1);
    step(0, 0, 0, 0, 0);
    check_eq("afull_off", int'(walmost_full), 0);

    // Streaming with reads trailing, crossing the binary rollover several times.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 1, (i >= 5), 0, 0);
    check_eq("roll_wtot", w_tot, 100);

    // Reset in the middle of a burst.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
    check_eq("burst_level", int'(wlevel), 7);
    step(1, 1, 0, 0, 0);
    check_eq("midrst_level", int'(wlevel), 0);
    check_eq("midrst_waddr", int'(waddr), 0);
    step(0, 1, 0, 0, 0);
    check_eq("after_rst_waddr", int'(waddr), 1);

    // Random traffic.
    begin
      logic [PW-1:0] thr;
      thr = 10;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) thr = PW'($urandom_range(0, 20));
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) == 0,
             thr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
